inv_sub_bytes_seq: RTL and testbench

INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

---
 rtl/inv_sub_bytes_seq.sv | 164 ++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes: a 128-bit state is substituted LANES bytes per cycle
// through a bank of inverse S-box lookups, with valid/ready handshakes on both sides.

module sbox_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 in GF(2^8); zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  logic [7:0] pre;

  // Undo the forward affine transform before inverting.
  assign pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  assign y   = gf_inv(pre);

endmodule

module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    data_q, data_d, data_sub;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];
  int              base;

  assign base = int'(cnt_q) * LANES;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i] = data_q[8*(15 - (base + i)) +: 8];
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      sbox_inv u_sbox (
        .a (lane_in[g]),
        .y (lane_out[g])
      );
    end
  endgenerate

  // Only the current group is overwritten; the rest of the state passes through.
  always_comb begin
    data_sub = data_q;
    for (int i = 0; i < LANES; i++) begin
      data_sub[8*(15 - (base + i)) +: 8] = lane_out[i];
    end
  end

  // Next-state, datapath and handshake decode; flush overrides everything last.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_state;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        data_d = data_sub;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_state;
            cnt_d   = '0;
            state_d = SUB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = data_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: vector table, random states against a
// table-based AES model, handshake/flush/reset corner cases and a LANES sweep.

module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;

  logic         sw_in_valid;
  logic [127:0] sw_in_state;
  logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
  logic [127:0] sw_out_state [4];

  int           errors = 0;
  int           checks = 0;
  logic [7:0]   inv_tbl [256];
  int           swlat [4];
  logic [127:0] swres [4];

  localparam logic [127:0] SEQ_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t vecs [16];

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  generate
    for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      inv_sub_bytes_seq #(.LANES(L)) u_sw (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .in_valid  (sw_in_valid),
        .in_ready  (sw_in_ready[g]),
        .in_state  (sw_in_state),
        .out_valid (sw_out_valid[g]),
        .out_ready (1'b1),
        .out_state (sw_out_state[g]),
        .busy      (sw_busy[g])
      );
    end
  endgenerate

  // Carry-less product reduced modulo the AES polynomial 0x11b.
  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // Forward S-box by brute-force inverse plus affine map, then inverted by indexing.
  task automatic buildTables();
    logic [7:0] b, s, xb;
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      b  = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul_ref(xb, 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      inv_tbl[s] = xb;
    end
  endtask

  function automatic logic [127:0] modelInvSub(input logic [127:0] st);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = inv_tbl[st[8*(15-k) +: 8]];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] st, input logic v, input logic ordy);
    in_state  = st;
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runOne(input logic [127:0] din, input logic [127:0] dexp, input string tag);
    int lat;
    @(negedge clk);
    applyStimulus(din, 1'b1, 1'b1);
    @(posedge clk); #1;
    checkOutput($sformatf("%s_in_ready_sub", tag), 128'(in_ready), 128'(0));
    in_valid = 1'b0;
    waitOutValid(lat);
    checkOutput($sformatf("%s_latency", tag), 128'(lat), 128'(4));
    checkOutput($sformatf("%s_data", tag), out_state, dexp);
    @(posedge clk); #1;
    checkOutput($sformatf("%s_idle", tag), 128'(busy), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic seen;
    rst_n = 1'b0;
    flush = 1'b0;
    sw_in_valid = 1'b0;
    sw_in_state = '0;
    applyStimulus('0, 1'b0, 1'b0);
    buildTables();
    #12;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_state", out_state, 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{din: {16{8'h63}}, dexp: {16{8'h00}}};
    vecs[1] = '{din: SEQ_IN,      dexp: SEQ_OUT};
    vecs[2] = '{din: {16{8'hff}}, dexp: {16{8'h7d}}};
    vecs[3] = '{din: {16{8'h7c}}, dexp: {16{8'h01}}};
    for (int i = 4; i < 16; i++) begin
      vecs[i].din  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].dexp = modelInvSub(vecs[i].din);
    end
    for (int i = 0; i < 16; i++) runOne(vecs[i].din, vecs[i].dexp, $sformatf("vec%0d", i));

    // Consumer stalls for five cycles: result must hold.
    @(negedge clk);
    applyStimulus(SEQ_IN, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall_valid_rise", 128'(out_valid), 128'(1));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_valid_%0d", c), 128'(out_valid), 128'(1));
      checkOutput($sformatf("stall_data_%0d", c), out_state, SEQ_OUT);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_release_idle", 128'(busy), 128'(0));

    // Back-to-back hand-off from DONE.
    @(negedge clk);
    applyStimulus({16{8'h63}}, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("b2b_first_valid", 128'(out_valid), 128'(1));
    checkOutput("b2b_first_data", out_state, {16{8'h00}});
    @(negedge clk);
    applyStimulus({16{8'hff}}, 1'b1, 1'b1);
    #1;
    checkOutput("b2b_in_ready_done", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("b2b_no_bubble_busy", 128'(busy), 128'(1));
    checkOutput("b2b_first_consumed", 128'(out_valid), 128'(0));
    waitOutValid(lat);
    checkOutput("b2b_second_latency", 128'(lat), 128'(4));
    checkOutput("b2b_second_data", out_state, {16{8'h7d}});
    @(posedge clk); #1;

    // Flush on the second SUB cycle.
    @(negedge clk);
    applyStimulus(SEQ_IN, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_idle", 128'(busy), 128'(0));
    checkOutput("flush_in_ready", 128'(in_ready), 128'(1));
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    checkOutput("flush_no_out_valid", 128'(seen), 128'(0));
    runOne({16{8'h7c}}, {16{8'h01}}, "post_flush");

    // Flush with a simultaneous accept discards the handshake.
    @(negedge clk);
    applyStimulus(SEQ_IN, 1'b1, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_accept_dropped", 128'(busy), 128'(0));

    // Asynchronous reset pulse in the middle of SUB.
    @(negedge clk);
    applyStimulus(SEQ_IN, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 128'(busy), 128'(0));
    checkOutput("arst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("arst_out_state", out_state, 128'(0));
    checkOutput("arst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    checkOutput("arst_no_stale_valid", 128'(seen), 128'(0));

    // Reset in DONE, then accept on the very first edge after release.
    @(negedge clk);
    applyStimulus({16{8'hff}}, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_done_valid", 128'(out_valid), 128'(0));
    applyStimulus(SEQ_IN, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("first_edge_accept", 128'(busy), 128'(1));
    waitOutValid(lat);
    checkOutput("first_edge_latency", 128'(lat), 128'(4));
    checkOutput("first_edge_data", out_state, SEQ_OUT);
    @(posedge clk); #1;

    // LANES sweep: same result, latency 16/LANES.
    for (int g = 0; g < 4; g++) begin
      swlat[g] = 0;
      swres[g] = '0;
    end
    @(negedge clk);
    sw_in_state = SEQ_IN;
    sw_in_valid = 1'b1;
    @(posedge clk); #1;
    sw_in_valid = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
        if (sw_out_valid[g] && swlat[g] == 0) begin
          swlat[g] = e;
          swres[g] = sw_out_state[g];
        end
      end
    end
    checkOutput("sweep_l1_latency", 128'(swlat[0]), 128'(16));
    checkOutput("sweep_l2_latency", 128'(swlat[1]), 128'(8));
    checkOutput("sweep_l8_latency", 128'(swlat[2]), 128'(2));
    checkOutput("sweep_l16_latency", 128'(swlat[3]), 128'(1));
    for (int g = 0; g < 4; g++) checkOutput($sformatf("sweep_data_%0d", g), swres[g], SEQ_OUT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
